// File: rtl/pla_engine.sv
// pla_engine: sequential programmable two-level PLA, TERMS_PER_CYC product terms per cycle.
// Optional match_cnt output enabled by defining PLA_ENGINE_MATCH_COUNT_EN.
module pla_engine #(
   parameter int N_IN          = 21,
   parameter int N_OUT         = 23,
   parameter int N_TERMS       = 64,
   parameter int TERMS_PER_CYC = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
   input  logic [N_IN-1:0]            cfg_care,
   input  logic [N_IN-1:0]            cfg_val,
   input  logic [N_OUT-1:0]           cfg_or,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_IN-1:0]            x,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_OUT-1:0]           z
`ifdef PLA_ENGINE_MATCH_COUNT_EN
   ,
   output logic [$clog2(N_TERMS+1)-1:0] match_cnt
`endif
);
   localparam int AW = $clog2(N_TERMS);
   localparam int B  = N_TERMS / TERMS_PER_CYC;
   localparam int BW = B > 1 ? $clog2(B) : 1;
   localparam int CW = $clog2(N_TERMS + 1);

   typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

   state_t             state, state_nx;
   logic [BW-1:0]      blk;
   logic [AW-1:0]      base;
   logic               last;
   logic [N_IN-1:0]    care [N_TERMS];
   logic [N_IN-1:0]    val  [N_TERMS];
   logic [N_OUT-1:0]   orr  [N_TERMS];
   logic [N_IN-1:0]    xr;
   logic [N_OUT-1:0]   acc, blk_or;
   logic [TERMS_PER_CYC-1:0] hit;

   assign last      = blk == BW'(B - 1);
   assign base      = AW'(int'(blk) * TERMS_PER_CYC);
   // rst_n gating keeps both ready flags low while reset is held
   assign in_ready  = rst_n && state == IDLE;
   assign cfg_ready = rst_n && state == IDLE;
   assign out_valid = state == HOLD;

   always_comb begin
      state_nx = state == IDLE ? (in_valid  ? EVAL : IDLE) :
                 state == EVAL ? (last      ? HOLD : EVAL) :
                                 (out_ready ? IDLE : HOLD);
   end

   always_comb begin
      hit    = '0;
      blk_or = '0;
      for (int i = 0; i < TERMS_PER_CYC; i++) begin
         hit[i] = ((xr ^ val[base + AW'(i)]) & care[base + AW'(i)]) == '0;
         blk_or = blk_or | (hit[i] ? orr[base + AW'(i)] : '0);
      end
   end

`ifdef PLA_ENGINE_MATCH_COUNT_EN
   logic [CW-1:0] cnt_acc, blk_cnt;
   always_comb begin
      blk_cnt = '0;
      for (int i = 0; i < TERMS_PER_CYC; i++)
         blk_cnt = blk_cnt + CW'(hit[i]);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         blk   <= '0;
         acc   <= '0;
         xr    <= '0;
         z     <= '0;
         for (int t = 0; t < N_TERMS; t++) begin
            care[t] <= '0;
            val[t]  <= '0;
            orr[t]  <= '0;
         end
`ifdef PLA_ENGINE_MATCH_COUNT_EN
         cnt_acc   <= '0;
         match_cnt <= '0;
`endif
      end else begin
         state <= state_nx;
         // out-of-range addresses are accepted but dropped
         if (cfg_ready && cfg_valid && 32'(cfg_addr) < N_TERMS) begin
            care[cfg_addr] <= cfg_care;
            val[cfg_addr]  <= cfg_val;
            orr[cfg_addr]  <= cfg_or;
         end
         if (state == IDLE && in_valid) begin
            xr  <= x;
            acc <= '0;
`ifdef PLA_ENGINE_MATCH_COUNT_EN
            cnt_acc <= '0;
`endif
         end
         if (state == EVAL) begin
            acc <= acc | blk_or;
            blk <= last ? '0 : blk + 1'b1;
            if (last) z <= acc | blk_or;
`ifdef PLA_ENGINE_MATCH_COUNT_EN
            cnt_acc <= cnt_acc + blk_cnt;
            if (last) match_cnt <= cnt_acc + blk_cnt;
`endif
         end
      end
   end
endmodule
